fp_op_sequencer: RTL
====================

# fp_op_sequencer

Issue-side controller for the floating-point unit: accepts FP operation requests from effect datapaths over a valid/ready port, queues them, drives the FP unit's `operation`/`clk_en`/`dataa`/`datab` interface, and waits for `done`. It captures the result and returns it, tagged, on a valid/ready response port. It is the single initiator in front of the FP unit and enforces one operation in flight, operand stability, and a done timeout.

## Interface
- `TIMEOUT`, 64: max cycles `fp_clk_en` stays high waiting for `fp_done`.
- `FIFO_DEPTH`, 4: request queue entries, a power of two ≥ 2.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  queue can accept; equals `!full`.
- `req_op`  in  3  opcode: 0 ADD, 1 SUB, 3 MUL, 4 F2I, 5 I2F, 6 CMP; 2 and 7 are illegal.
- `req_a`, `req_b`  in  32  operands; `req_b` is ignored by F2I/I2F but passed through.
- `req_tag`  in  4  requester tag, echoed on the response.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_result`  out  32  captured `fp_result`, or 0 on error.
- `rsp_tag`  out  4  tag of the request.
- `rsp_err`  out  2  00 ok, 01 illegal opcode, 10 timeout.
- `fp_operation`  out  3  to FP unit.
- `fp_clk_en`  out  1  to FP unit; high for the whole operation.
- `fp_dataa`, `fp_datab`  out  32  to FP unit.
- `fp_result`  in  32  from FP unit.
- `fp_done`  in  1  from FP unit.
- `busy`  out  1  `state != IDLE || !empty`.

## Operation
- FIFO stores `{op, a, b, tag}`. Push on `req_valid && req_ready`. Pop only in IDLE when the FIFO is non-empty. Push and pop can occur in the same cycle; the count is unchanged. No push when full, even if a pop occurs in the same cycle.
- FSM states: IDLE, RUN, RESP.
- **IDLE, FIFO non-empty:** pop the head into operand, op and tag registers.
  - Legal opcode: set `fp_clk_en <= 1`, clear the timeout counter, go to RUN.
  - Illegal opcode: `rsp_result <= 0`, `rsp_err <= 01`, `rsp_valid <= 1`, go to RESP. `fp_clk_en` stays 0.
- **RUN:** `fp_operation`, `fp_dataa` and `fp_datab` are held constant. Each edge:
  - `fp_done == 1`: capture `fp_result`, `rsp_err <= 00`, `fp_clk_en <= 0`, `rsp_valid <= 1`, go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT-1`: `rsp_result <= 0`, `rsp_err <= 10`, `fp_clk_en <= 0`, `rsp_valid <= 1`, go to RESP.
  - Otherwise: increment the counter.
  - `fp_done` and timeout in the same cycle: `fp_done` wins.
- **RESP:** hold all `rsp_*` stable until `rsp_ready`. On the handshake edge, `rsp_valid <= 0` and go to IDLE.
- `fp_done` is ignored whenever `fp_clk_en == 0`, so a stale done in IDLE or RESP has no effect.
- Counter width is `clog2(TIMEOUT+1)`. It does not wrap; RUN exits before it overflows.
- `fp_operation`, `fp_dataa` and `fp_datab` keep their last issued values between operations.
- Responses are returned in request order.

## Timing
- **Reset** (`reset_n` low at an edge):
  - State IDLE; FIFO emptied.
  - `fp_clk_en`, `rsp_valid`, `busy` = 0.
  - `fp_operation`, `fp_dataa`, `fp_datab`, `rsp_result`, `rsp_tag`, `rsp_err` = 0.
  - `req_ready` = 1 from the first cycle after reset.
  - Reset during RUN drops `fp_clk_en` at that edge; a later `fp_done` is ignored.
- **Issue latency:** request accepted at edge t into an empty FIFO with the FSM in IDLE gives `fp_clk_en` high after edge t+1.
- **Done latency:** if `fp_done` is sampled high at edge t+1+k, then `rsp_valid` is high and `fp_clk_en` low after that same edge. `fp_clk_en` is high for exactly k cycles.
- **Gap between operations:** at least 2 cycles with `fp_clk_en` low (RESP plus IDLE), even with `rsp_ready` tied high.
- **Illegal opcode:** `rsp_valid` rises one edge after the pop.
- **Timeout:** `fp_clk_en` is high exactly `TIMEOUT` cycles.
- **Capacity:** `FIFO_DEPTH` queued requests plus 1 in flight.

## Test plan
- **Reset:** hold `reset_n` low for 3 cycles mid-stream -> all outputs 0, `req_ready` = 1, no response emitted afterwards.
- **Single ADD:** `req_op` = 0, a = 0x3F800000, b = 0x40000000, tag = 5; stub raises `fp_done` after 7 enable cycles with 0x40400000 -> `rsp_result` = 0x40400000, `rsp_err` = 00, `rsp_tag` = 5, `fp_clk_en` high exactly 7 cycles, operands stable throughout.
- **Backpressure:** 6 back-to-back MUL requests, tags 0..5, `rsp_ready` = 0 -> 5 accepted, `req_ready` drops before the 6th. Release `rsp_ready` -> tags return 0..5 in order, each result matches the stub, `fp_clk_en` low at least 2 cycles between operations.
- **Illegal opcode:** `req_op` = 2 followed by CMP -> first response `rsp_err` = 01, `rsp_result` = 0, no `fp_clk_en` pulse for it. CMP then completes normally.
- **Timeout:** stub never asserts done, `TIMEOUT` = 64 -> `fp_clk_en` high exactly 64 cycles, `rsp_err` = 10. A stale `fp_done` one cycle later is ignored and the next request is processed normally.
- **Done/timeout collision:** stub asserts `fp_done` in the 64th enable cycle -> `rsp_err` = 00 and the result is captured. Separately, a stub asserting `fp_done` while `fp_clk_en` is low must not cause a state change.

Source files
------------

// File: rtl/fp_op_sequencer_if.sv
// fp_op_sequencer_if: request/response valid-ready ports of the FP issue sequencer.
interface fp_op_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_tag;
   logic [1:0]  rsp_err;
   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
   );
   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err
   );
endinterface

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: queues FP requests, issues one at a time to the FP unit with a done timeout, returns tagged responses.
module fp_op_sequencer #(
   parameter int TIMEOUT    = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   fp_op_sequencer_if.slave     bus,
   output logic [2:0]           fp_operation,
   output logic                 fp_clk_en,
   output logic [31:0]          fp_dataa,
   output logic [31:0]          fp_datab,
   input  logic [31:0]          fp_result,
   input  logic                 fp_done,
   output logic                 busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
   state_t state, next_state;
   logic [70:0] mem [FIFO_DEPTH];
   logic [70:0] head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [CW-1:0] cnt;
   logic push, pop, empty, full, legal, expired;
   assign head    = mem[rd_ptr];
   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign push    = bus.req_valid && !full;
   assign pop     = state == IDLE && !empty;
   assign legal   = head[70:68] != 3'd2 && head[70:68] != 3'd7;
   assign expired = cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clock)
      state <= !reset_n ? IDLE : next_state;
   always_comb
      next_state = state == IDLE ? (empty ? IDLE : legal ? RUN : RESP)
                 : state == RUN  ? ((fp_done || expired) ? RESP : RUN)
                 : bus.rsp_ready ? IDLE : RESP;
   always_comb begin
      fp_clk_en     = state == RUN;
      bus.rsp_valid = state == RESP;
      bus.req_ready = !full;
      busy          = state != IDLE || !empty;
   end
   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= {bus.req_op, bus.req_a, bus.req_b, bus.req_tag};
   // fp_done only matters in RUN, so a stray done while disabled is ignored.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         cnt            <= '0;
         fp_operation   <= '0;
         fp_dataa       <= '0;
         fp_datab       <= '0;
         bus.rsp_result <= '0;
         bus.rsp_tag    <= '0;
         bus.rsp_err    <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (pop) begin
            bus.rsp_tag <= head[3:0];
            cnt         <= '0;
            if (legal) {fp_operation, fp_dataa, fp_datab} <= head[70:4];
            else begin
               bus.rsp_result <= '0;
               bus.rsp_err    <= 2'b01;
            end
         end
         if (state == RUN) begin
            if (fp_done) begin
               bus.rsp_result <= fp_result;
               bus.rsp_err    <= 2'b00;
            end else if (expired) begin
               bus.rsp_result <= '0;
               bus.rsp_err    <= 2'b10;
            end else cnt <= cnt + CW'(1);
         end
      end
   end
endmodule
